// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART program loader
package uart_loader_pkg;

  typedef enum logic [2:0] {
    L_IDLE,
    L_LEN0,
    L_LEN1,
    L_DATA,
    L_SUM,
    L_DONE,
    L_ERROR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned MAX_WORDS = 16384;

endpackage

// File: rtl/uart_loader_rx.sv
// rtl/uart_loader_rx.sv - 8N1 UART receiver with input synchronizer and start-bit glitch rejection
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int DIV = 1085
) (
  input  logic       clk_125mhz,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] rx_data
);

  localparam int            CW      = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rxd;
      sync2      <= sync1;
      rx_prev    <= sync2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !sync2) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // Mid-start-bit recheck: a line already back high was a glitch.
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync2) begin
              byte_valid <= 1'b1;
              rx_data    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed serial image loader driving the instruction/data memory write port
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ      = 125000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 12500000
) (
  input  logic        clk_125mhz,
  input  logic        reset,
  input  logic        rxd,
  output logic        mem_we,
  output logic [13:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int            DIV          = CLK_HZ / BAUD;
  localparam int            TW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  logic          byte_valid;
  logic          frame_err;
  logic [7:0]    rx_data;
  load_state_t   state;
  logic [7:0]    len_lo;
  logic [13:0]   last_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    chk;
  logic [TW-1:0] gap_cnt;
  logic [15:0]   len_word;
  logic          timed_out;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_data    (rx_data)
  );

  assign mem_byteen = 4'hF;
  assign len_word   = {rx_data, len_lo};
  assign timed_out  = busy && !byte_valid && (gap_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state     <= L_IDLE;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len_lo    <= '0;
      last_idx  <= '0;
      byte_idx  <= '0;
      chk       <= '0;
      gap_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      // The strobe of the final word leaves DATA, so the address never steps past N-1.
      if (mem_we && state == L_DATA) mem_adr <= mem_adr + 14'd1;
      if (byte_valid || !busy) gap_cnt <= '0;
      else gap_cnt <= gap_cnt + TW'(1);

      case (state)
        L_IDLE, L_DONE, L_ERROR: begin
          if (byte_valid && rx_data == SYNC_BYTE) begin
            state     <= L_LEN0;
            busy      <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: begin
          if (frame_err || timed_out) begin
            state <= L_ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (byte_valid) begin
            case (state)
              L_LEN0: begin
                len_lo <= rx_data;
                state  <= L_LEN1;
              end
              L_LEN1: begin
                if (len_word == 16'd0 || 32'(len_word) > MAX_WORDS) begin
                  state <= L_ERROR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  last_idx <= 14'(len_word - 16'd1);
                  mem_adr  <= '0;
                  chk      <= '0;
                  byte_idx <= '0;
                  state    <= L_DATA;
                end
              end
              L_DATA: begin
                mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                chk      <= chk ^ rx_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  mem_we <= 1'b1;
                  if (mem_adr == last_idx) state <= L_SUM;
                end
              end
              L_SUM: begin
                if (rx_data == chk) begin
                  state     <= L_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cpu_reset <= 1'b0;
                end else begin
                  state <= L_ERROR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                end
              end
              default: state <= L_ERROR;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - randomized self-checking bench for uart_loader with a frame-level model
module tb_uart_loader;

  localparam int CLK_HZ      = 125_000_000;
  localparam int BAUD        = 12_500_000;
  localparam int DIV         = CLK_HZ / BAUD;
  localparam int TIMEOUT_CYC = 300;

  logic        clk_125mhz = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic        mem_we;
  logic [13:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [13:0] wr_adr[$];
  logic [31:0] wr_data[$];
  logic [31:0] words[$];
  logic [7:0]  tx[$];

  uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .rxd        (rxd),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  always @(negedge clk_125mhz) begin
    if (mem_we) begin
      wr_adr.push_back(mem_adr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_125mhz);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(DIV);
    end
    rxd = stop;
    idle(DIV);
    rxd = 1'b1;
    idle(2);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi && i < tx.size(); i++) send_byte(tx[i], 1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      w[8*k +: 8] = b;
    end
    return w;
  endfunction

  // Frame = sync, 16-bit LE count, words as LE bytes, XOR of data bytes (optionally corrupted).
  task automatic make_frame(input logic [15:0] n, input logic [7:0] chk_flip);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    tx.delete();
    tx.push_back(8'hA5);
    tx.push_back(n[7:0]);
    tx.push_back(n[15:8]);
    foreach (words[w]) begin
      for (int k = 0; k < 4; k++) begin
        b = words[w][8*k +: 8];
        tx.push_back(b);
        x = x ^ b;
      end
    end
    tx.push_back(x ^ chk_flip);
  endtask

  task automatic clear_log();
    wr_adr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd = 1'b1;
    idle(3);
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_adr !== 14'd0) $display("FAIL rst_adr: got %0h want 0", mem_adr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'd0) $display("FAIL rst_wdata: got %0h want 0", mem_wdata); else pass_cnt++;
    total_cnt++; if (mem_byteen !== 4'hF) $display("FAIL rst_byteen: got %0h want f", mem_byteen); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_basic();
    words.delete();
    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    make_frame(16'd2, 8'h00);
    clear_log();
    send_range(0, tx.size() - 1);
    idle(5);
    total_cnt++; if (wr_data.size() != 2) $display("FAIL basic_nwr: got %0d want 2", wr_data.size()); else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < 2; i++) begin
      total_cnt++;
      if (wr_adr[i] !== 14'(i) || wr_data[i] !== words[i])
        $display("FAIL basic_wr%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_adr[i], words[i], i);
      else pass_cnt++;
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL basic_cpu_reset: got %b want 0", cpu_reset); else pass_cnt++;
    total_cnt++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL basic_err_busy: got %b%b want 00", err, busy); else pass_cnt++;
  endtask

  task automatic test_bad_chk();
    int n;
    words.delete();
    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    make_frame(16'd2, 8'h01);
    clear_log();
    send_range(0, tx.size() - 1);
    idle(5);
    total_cnt++; if (wr_data.size() != 2) $display("FAIL badchk_nwr: got %0d want 2", wr_data.size()); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL badchk_err: got %b want 1", err); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1 || done !== 1'b0) $display("FAIL badchk_cpu_done: got %b%b want 10", cpu_reset, done); else pass_cnt++;
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(1, 4);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      make_frame(16'(n), 8'h00);
      clear_log();
      send_range(0, tx.size() - 1);
      idle(5);
      total_cnt++; if (wr_data.size() != n) $display("FAIL resend_nwr: got %0d want %0d", wr_data.size(), n); else pass_cnt++;
      for (int i = 0; i < wr_data.size() && i < n; i++) begin
        total_cnt++;
        if (wr_adr[i] !== 14'(i) || wr_data[i] !== words[i])
          $display("FAIL resend_wr%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_adr[i], words[i], i);
        else pass_cnt++;
      end
      total_cnt++; if (done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b0)
        $display("FAIL resend_flags: got done%b cpu%b err%b want 1 0 0", done, cpu_reset, err); else pass_cnt++;
    end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens[2];
    lens[0] = 16'd0;
    lens[1] = 16'd16385;
    for (int j = 0; j < 2; j++) begin
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(lens[j][7:0], 1'b1);
      total_cnt++; if (busy !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b1)
        $display("FAIL badlen_start%0d: got busy%b err%b cpu%b want 1 0 1", j, busy, err, cpu_reset); else pass_cnt++;
      send_byte(lens[j][15:8], 1'b1);
      idle(5);
      total_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL badlen_err%0d: got err%b busy%b want 1 0", j, err, busy); else pass_cnt++;
      total_cnt++; if (wr_data.size() != 0) $display("FAIL badlen_nwr%0d: got %0d want 0", j, wr_data.size()); else pass_cnt++;
    end
  endtask

  task automatic test_stop_err();
    words.delete();
    words.push_back(rand_word());
    words.push_back(rand_word());
    make_frame(16'd2, 8'h00);
    clear_log();
    send_range(0, 4);
    send_byte(tx[5], 1'b0);
    send_range(6, 10);
    idle(5);
    total_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL stoperr_err: got err%b busy%b want 1 0", err, busy); else pass_cnt++;
    total_cnt++; if (wr_data.size() != 0) $display("FAIL stoperr_nwr: got %0d want 0", wr_data.size()); else pass_cnt++;
  endtask

  task automatic test_glitch();
    words.delete();
    words.push_back($urandom);
    make_frame(16'd1, 8'h00);
    clear_log();
    send_range(0, 4);
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(40);
    send_range(5, tx.size() - 1);
    idle(5);
    total_cnt++; if (wr_data.size() != 1) $display("FAIL glitch_nwr: got %0d want 1", wr_data.size()); else pass_cnt++;
    if (wr_data.size() > 0) begin
      total_cnt++; if (wr_data[0] !== words[0] || wr_adr[0] !== 14'd0)
        $display("FAIL glitch_wr: got %0h@%0d want %0h@0", wr_data[0], wr_adr[0], words[0]); else pass_cnt++;
    end
    total_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL glitch_done: got done%b err%b want 1 0", done, err); else pass_cnt++;
  endtask

  task automatic test_timeout();
    words.delete();
    words.push_back(rand_word());
    words.push_back(rand_word());
    make_frame(16'd2, 8'h00);
    clear_log();
    send_range(0, 4);
    total_cnt++; if (busy !== 1'b1 || err !== 1'b0) $display("FAIL tmo_busy: got busy%b err%b want 1 0", busy, err); else pass_cnt++;
    idle(TIMEOUT_CYC + 1);
    total_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL tmo_err: got err%b busy%b want 1 0", err, busy); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1 || wr_data.size() != 0)
      $display("FAIL tmo_state: got cpu%b nwr%0d want 1 0", cpu_reset, wr_data.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    words.delete();
    words.push_back(rand_word());
    words.push_back(rand_word());
    make_frame(16'd2, 8'h00);
    clear_log();
    send_range(0, 7);
    total_cnt++; if (wr_data.size() != 1) $display("FAIL rmid_pre_nwr: got %0d want 1", wr_data.size()); else pass_cnt++;
    @(negedge clk_125mhz);
    #1 reset = 1'b1;
    #1;
    total_cnt++; if (mem_we !== 1'b0 || mem_adr !== 14'd0 || mem_wdata !== 32'd0)
      $display("FAIL rmid_mem: got we%b adr%0h wdata%0h want 0 0 0", mem_we, mem_adr, mem_wdata); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL rmid_flags: got cpu%b busy%b done%b err%b want 1 0 0 0", cpu_reset, busy, done, err); else pass_cnt++;
    idle(2);
    reset = 1'b0;
    idle(3);
    clear_log();
    send_range(8, 10);
    idle(5);
    total_cnt++; if (wr_data.size() != 0 || busy !== 1'b0 || cpu_reset !== 1'b1)
      $display("FAIL rmid_ignore: got nwr%0d busy%b cpu%b want 0 0 1", wr_data.size(), busy, cpu_reset); else pass_cnt++;
    clear_log();
    send_range(0, tx.size() - 1);
    idle(5);
    total_cnt++; if (wr_data.size() != 2) $display("FAIL rmid_nwr: got %0d want 2", wr_data.size()); else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < 2; i++) begin
      total_cnt++;
      if (wr_adr[i] !== 14'(i) || wr_data[i] !== words[i])
        $display("FAIL rmid_wr%0d: got %0h@%0d want %0h@%0d", i, wr_data[i], wr_adr[i], words[i], i);
      else pass_cnt++;
    end
    total_cnt++; if (done !== 1'b1 || cpu_reset !== 1'b0) $display("FAIL rmid_done: got done%b cpu%b want 1 0", done, cpu_reset); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_bad_len();
    test_stop_err();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
